// File: rtl/data_write_buffer.sv
// rtl/data_write_buffer.sv - write buffer between the store path and the AXI write bridge
//
// Purpose: holds pending line writes (cached) and word writes (uncached) in a
// circular FIFO, drains them in order to the downstream bridge, merges
// repeated cached writes to the same line into the youngest entry, and lets
// loads look up and forward buffered line data.
//
// Ports:
//   clk, resetn        clock; reset is asynchronous and active-high (resetn=1 clears)
//   wb_req/wb_ready    push handshake; entry = {wb_uncached, wb_addr, wb_we, wb_wdata}
//   data_w*            head entry presented downstream; data_waddr_ok pops it
//   rd_addr            load lookup address; rd_hit, rd_fwd_valid, rd_fwd_data results
//   empty, count       occupancy status
module data_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wb_req,
  input  logic                       wb_uncached,
  input  logic [31:0]                wb_addr,
  input  logic [3:0]                 wb_we,
  input  logic [LINE_WORDS*32-1:0]   wb_wdata,
  output logic                       wb_ready,
  output logic                       data_wreq,
  output logic                       data_wuncached,
  output logic [31:0]                data_waddr,
  output logic [3:0]                 data_we,
  output logic [LINE_WORDS*32-1:0]   data_wdata,
  input  logic                       data_waddr_ok,
  input  logic [31:0]                rd_addr,
  output logic                       rd_hit,
  output logic                       rd_fwd_valid,
  output logic [LINE_WORDS*32-1:0]   rd_fwd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = LINE_WORDS * 32;
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              ent_unc   [DEPTH];
  logic [31:0]       ent_addr  [DEPTH];
  logic [3:0]        ent_we    [DEPTH];
  logic [DATA_W-1:0] ent_wdata [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] young;

  logic push;
  logic pop;
  logic merge;
  logic push_new;

  // Byte offset within a line never affects lookup.
  logic unused_rd_offset;
  assign unused_rd_offset = ^rd_addr[OFF_W-1:0];

  assign wb_ready       = (count != FULL);
  assign data_wreq      = (count != '0);
  assign empty          = (count == '0);
  assign data_wuncached = ent_unc[head];
  assign data_waddr     = ent_addr[head];
  assign data_we        = ent_we[head];
  assign data_wdata     = ent_wdata[head];

  assign young = tail - PTR_W'(1);
  assign push  = wb_req && wb_ready;
  assign pop   = data_wreq && data_waddr_ok;

  // The head may be consumed downstream this very cycle, so merging needs at
  // least two entries: the youngest is then guaranteed not to be the head.
  assign merge = push && !wb_uncached && (count >= CNT_W'(2)) && !ent_unc[young] &&
                 (ent_addr[young][31:OFF_W] == wb_addr[31:OFF_W]);
  assign push_new = push && !merge;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)
        head <= head + PTR_W'(1);
      if (push_new)
        tail <= tail + PTR_W'(1);
      if (push_new && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push_new)
        count <= count - CNT_W'(1);
    end
  end

  // Payload is only meaningful while counted as valid, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_new) begin
      ent_unc[tail]   <= wb_uncached;
      ent_addr[tail]  <= wb_addr;
      ent_we[tail]    <= wb_we;
      ent_wdata[tail] <= wb_wdata;
    end else if (merge) begin
      ent_wdata[young] <= wb_wdata;
    end
  end

  // Walk oldest to youngest so the youngest match determines forwarding.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rd_hit       = 1'b0;
    rd_fwd_valid = 1'b0;
    rd_fwd_data  = '0;
    idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ent_addr[idx][31:OFF_W] == rd_addr[31:OFF_W])) begin
        rd_hit       = 1'b1;
        rd_fwd_valid = !ent_unc[idx];
        rd_fwd_data  = ent_unc[idx] ? '0 : ent_wdata[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// tb/tb_data_write_buffer.sv - self-checking bench for data_write_buffer
module tb_data_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         wb_req = 1'b0;
  logic         wb_uncached = 1'b0;
  logic [31:0]  wb_addr = '0;
  logic [3:0]   wb_we = '0;
  logic [255:0] wb_wdata = '0;
  logic         wb_ready;
  logic         data_wreq;
  logic         data_wuncached;
  logic [31:0]  data_waddr;
  logic [3:0]   data_we;
  logic [255:0] data_wdata;
  logic         data_waddr_ok = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_hit;
  logic         rd_fwd_valid;
  logic [255:0] rd_fwd_data;
  logic         empty;
  logic [2:0]   count;

  data_write_buffer #(.DEPTH(DEPTH), .LINE_WORDS(8)) dut (
    .clk(clk), .resetn(resetn),
    .wb_req(wb_req), .wb_uncached(wb_uncached), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_wdata(wb_wdata), .wb_ready(wb_ready),
    .data_wreq(data_wreq), .data_wuncached(data_wuncached), .data_waddr(data_waddr),
    .data_we(data_we), .data_wdata(data_wdata), .data_waddr_ok(data_waddr_ok),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_fwd_valid(rd_fwd_valid),
    .rd_fwd_data(rd_fwd_data), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           unc;
    logic [31:0]  addr;
    logic [3:0]   we;
    logic [255:0] data;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: the buffer as an ordered queue of writes.
  task automatic tick();
    bit   ready, do_pop, do_push, do_merge;
    ent_t e;
    int   n;
    n        = q.size();
    ready    = (n != DEPTH);
    do_pop   = (n != 0) && data_waddr_ok;
    do_push  = wb_req && ready;
    do_merge = 1'b0;
    if (do_push && !wb_uncached && n >= 2)
      do_merge = !q[n-1].unc && (q[n-1].addr[31:5] == wb_addr[31:5]);
    e.unc  = wb_uncached;
    e.addr = wb_addr;
    e.we   = wb_we;
    e.data = wb_wdata;
    @(posedge clk);
    if (resetn) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_merge) begin
        ent_t y;
        y = q[q.size()-1];
        y.data = e.data;
        q[q.size()-1] = y;
      end else if (do_push) begin
        q.push_back(e);
      end
    end
    #1;
  endtask

  function automatic void lookup(input logic [31:0] a, output bit hit, output bit fv,
                                 output logic [255:0] fd);
    hit = 0; fv = 0; fd = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr[31:5] == a[31:5]) begin
        hit = 1;
        fv  = !q[i].unc;
        fd  = q[i].unc ? 256'd0 : q[i].data;
        break;
      end
    end
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    wb_req = 0; data_waddr_ok = 0;
    resetn = 1;
    @(posedge clk); #1;
    q.delete();
    resetn = 0;
    #1;
  endtask

  task automatic push(input bit unc, input logic [31:0] a, input logic [255:0] d);
    wb_req = 1; wb_uncached = unc; wb_addr = a; wb_we = 4'hf; wb_wdata = d;
    tick();
    wb_req = 0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1; wb_req = 1; wb_uncached = 0; wb_addr = 32'h100; rd_addr = 32'h100;
    @(posedge clk); @(posedge clk); #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wb_ready); end
    total++; if (data_wreq !== 1'b0) begin bad++; $display("FAIL reset_wreq got=%b exp=0", data_wreq); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (rd_hit !== 1'b0 || rd_fwd_valid !== 1'b0 || rd_fwd_data !== 256'd0) begin
      bad++; $display("FAIL reset_lookup got=%b/%b exp=0/0", rd_hit, rd_fwd_valid); end
    wb_req = 0; resetn = 0; q.delete();
    @(posedge clk); #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_release_count got=%0d exp=0", count); end
  endtask

  task automatic test_single_push();
    do_reset();
    push(0, 32'h0000_1000, 256'h1234);
    total++; if (data_wreq !== 1'b1) begin bad++; $display("FAIL single_wreq got=%b exp=1", data_wreq); end
    total++; if (data_waddr !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h exp=00001000", data_waddr); end
    total++; if (data_wuncached !== 1'b0) begin bad++; $display("FAIL single_unc got=%b exp=0", data_wuncached); end
    total++; if (count !== 3'd1 || empty !== 1'b0) begin bad++; $display("FAIL single_count got=%0d/%b exp=1/0", count, empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 32'h2000 + 32'(i) * 32'h40, 256'(i));
    total++; if (count !== 3'd4 || wb_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, wb_ready); end
    push(0, 32'h9000, 256'h99);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_reject got=%0d exp=4", count); end
    data_waddr_ok = 1; tick(); data_waddr_ok = 0; #1;
    total++; if (count !== 3'd3 || wb_ready !== 1'b1) begin bad++; $display("FAIL full_pop got=%0d/%b exp=3/1", count, wb_ready); end
    total++; if (data_waddr !== 32'h2040) begin bad++; $display("FAIL full_head got=%h exp=00002040", data_waddr); end
  endtask

  task automatic test_merge();
    logic [255:0] d2;
    d2 = rand_line();
    do_reset();
    push(0, 32'h2000, 256'hA);
    push(0, 32'h3000, 256'hB);
    push(0, 32'h3010, d2);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL merge_count got=%0d exp=2", count); end
    push(1, 32'h3004, 256'hC);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL merge_unc_count got=%0d exp=3", count); end
    data_waddr_ok = 1; tick(); data_waddr_ok = 0; #1;
    total++; if (data_waddr !== 32'h3000 || data_wdata !== d2) begin
      bad++; $display("FAIL merge_data got=%h exp=%h", data_wdata[31:0], d2[31:0]); end
  endtask

  task automatic test_forward();
    logic [255:0] d;
    d = rand_line();
    do_reset();
    push(0, 32'h4000, d);
    rd_addr = 32'h4018; #1;
    total++; if (rd_hit !== 1'b1 || rd_fwd_valid !== 1'b1 || rd_fwd_data !== d) begin
      bad++; $display("FAIL fwd_cached got=%b/%b exp=1/1", rd_hit, rd_fwd_valid); end
    wb_req = 1; wb_uncached = 1; wb_addr = 32'h4004; wb_wdata = 256'h55; #1;
    total++; if (rd_fwd_valid !== 1'b1) begin bad++; $display("FAIL fwd_same_cycle got=%b exp=1", rd_fwd_valid); end
    tick(); wb_req = 0; #1;
    total++; if (rd_hit !== 1'b1 || rd_fwd_valid !== 1'b0 || rd_fwd_data !== 256'd0) begin
      bad++; $display("FAIL fwd_uncached got=%b/%b exp=1/0", rd_hit, rd_fwd_valid); end
  endtask

  task automatic test_back_to_back();
    int pushed, popped;
    logic [31:0] exp_addr;
    do_reset();
    push(0, 32'h5000, 256'h1);
    wb_req = 1; wb_uncached = 0; wb_addr = 32'h6000; wb_wdata = 256'h2; data_waddr_ok = 1;
    tick(); wb_req = 0; data_waddr_ok = 0; #1;
    total++; if (count !== 3'd1 || data_waddr !== 32'h6000) begin
      bad++; $display("FAIL pushpop got=%0d/%h exp=1/00006000", count, data_waddr); end
    do_reset();
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      wb_req = (pushed < 10); wb_uncached = pushed[0];
      wb_addr = 32'h8000 + 32'(pushed) * 32'h20; wb_wdata = 256'(pushed);
      data_waddr_ok = ($urandom % 2) == 0;
      #1;
      if (data_wreq && data_waddr_ok) begin
        exp_addr = 32'h8000 + 32'(popped) * 32'h20;
        total++; if (data_waddr !== exp_addr) begin
          bad++; $display("FAIL wrap_order got=%h exp=%h", data_waddr, exp_addr); end
        popped++;
      end
      if (wb_req && wb_ready) pushed++;
      tick();
    end
    wb_req = 0; data_waddr_ok = 0;
    total++; if (popped != 10) begin bad++; $display("FAIL wrap_drain got=%0d exp=10", popped); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(0, 32'hA000 + 32'(i) * 32'h20, 256'(i));
    data_waddr_ok = 1; #1;
    resetn = 1; #1;
    total++; if (data_wreq !== 1'b0 || count !== 3'd0 || wb_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", data_wreq, count, wb_ready); end
    @(posedge clk); #1;
    resetn = 0; q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (data_wreq !== 1'b0 || count !== 3'd0) begin
        bad++; $display("FAIL mid_reset_nopop got=%b/%0d exp=0/0", data_wreq, count); end
    end
    data_waddr_ok = 0;
  endtask

  task automatic test_random();
    bit e_hit, e_fv;
    logic [255:0] e_fd;
    int n;
    do_reset();
    repeat (600) begin
      wb_req        = ($urandom % 3) != 0;
      wb_uncached   = ($urandom % 4) == 0;
      wb_addr       = 32'h1000 + 32'($urandom % 3) * 32'h20 + 32'($urandom % 8) * 32'h4;
      wb_we         = 4'($urandom);
      wb_wdata      = rand_line();
      data_waddr_ok = ($urandom % 3) == 0;
      rd_addr       = 32'h1000 + 32'($urandom % 4) * 32'h20 + 32'($urandom % 32);
      #1;
      n = q.size();
      lookup(rd_addr, e_hit, e_fv, e_fd);
      total++; if (count !== 3'(n)) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", count, n); end
      total++; if (wb_ready !== (n != DEPTH)) begin bad++; $display("FAIL rnd_ready got=%b exp=%b", wb_ready, n != DEPTH); end
      total++; if (data_wreq !== (n != 0) || empty !== (n == 0)) begin
        bad++; $display("FAIL rnd_wreq got=%b/%b n=%0d", data_wreq, empty, n); end
      if (n != 0) begin
        total++; if (data_waddr !== q[0].addr || data_wuncached !== q[0].unc ||
                     data_we !== q[0].we || data_wdata !== q[0].data) begin
          bad++; $display("FAIL rnd_head got=%h exp=%h", data_waddr, q[0].addr); end
      end
      total++; if (rd_hit !== e_hit || rd_fwd_valid !== e_fv || rd_fwd_data !== e_fd) begin
        bad++; $display("FAIL rnd_lookup got=%b/%b exp=%b/%b addr=%h", rd_hit, rd_fwd_valid, e_hit, e_fv, rd_addr); end
      tick();
    end
    wb_req = 0; data_waddr_ok = 0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_merge();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of two, >=2).
REQ-002 SHALL have parameter LINE_WORDS, default 8, 32-bit words per cache line (line = 256 bits, line address = addr[31:5]).
REQ-003 SHALL have ports `clk  input  1  clock` and `resetn  input  1  reset` (one clock; reset asynchronous, active-high, asserted when resetn=1).
REQ-004 SHALL have ports wb_req in 1 (push request), wb_uncached in 1, wb_addr in 32, wb_we in 4 (uncached byte enables), wb_wdata in 256 (uncached word in [31:0]), wb_ready out 1 (push accepted when wb_req&&wb_ready).
REQ-005 SHALL have ports data_wreq out 1, data_wuncached out 1, data_waddr out 32, data_we out 4, data_wdata out 256, data_waddr_ok in 1 (downstream AXI bridge write port).
REQ-006 SHALL have ports rd_addr in 32 (load lookup), rd_hit out 1, rd_fwd_valid out 1, rd_fwd_data out 256, empty out 1, count out log2(DEPTH)+1.

Function
REQ-007 SHALL hold entries {uncached, addr, we, wdata} in a circular FIFO with head pointer, tail pointer and occupancy count.
REQ-008 SHALL drive wb_ready = (count != DEPTH), from registered state only; no push at full even if a pop occurs that cycle.
REQ-009 SHALL drive data_wreq = (count != 0) and data_w* from head entry; all combinational from registers.
REQ-010 SHALL pop head on the rising edge where data_wreq && data_waddr_ok; head wraps DEPTH-1 -> 0.
REQ-011 SHALL, on push without merge, write the entry at tail and advance tail (wraps DEPTH-1 -> 0).
REQ-012 SHALL merge a push into the youngest entry (replace wdata, no count change) when push cached, youngest cached, same addr[31:5], and count>=2; otherwise append.
REQ-013 SHALL never merge into head entry (count==1), since head may be accepted downstream that cycle.
REQ-014 SHALL update count as +1 on non-merged push only, -1 on pop only, unchanged on both or neither; simultaneous push and pop at count==1 yields count==1 with new entry at head next cycle.
REQ-015 SHALL compute rd_hit = 1 if any valid entry's addr[31:5] equals rd_addr[31:5], cached or uncached.
REQ-016 SHALL drive rd_fwd_valid = 1 and rd_fwd_data = that entry's wdata only when the youngest matching entry is cached; else rd_fwd_valid=0, rd_fwd_data=0.
REQ-017 SHALL evaluate lookup against state before the current edge (push in same cycle not visible until next cycle).
REQ-018 SHALL drive empty = (count == 0).
REQ-019 SHALL preserve strict FIFO order between cached and uncached entries; uncached entries never merge.

Reset
REQ-020 SHALL, while resetn=1, asynchronously clear head, tail, count and all valid state; entry payload need not reset.
REQ-021 SHALL output after reset: data_wreq=0, wb_ready=1, empty=1, count=0, rd_hit=0, rd_fwd_valid=0, rd_fwd_data=0; pushes during reset ignored.
REQ-022 SHALL discard all entries, including one mid-handshake, when reset asserts during operation.

Verification
REQ-023 Push cached line 0x0000_1000 with data_waddr_ok=0 -> next cycle data_wreq=1, data_waddr=0x0000_1000, data_wuncached=0, count=1, empty=0.
REQ-024 Push 4 entries, data_waddr_ok=0 -> count=4, wb_ready=0; 5th wb_req not accepted; raise data_waddr_ok one cycle -> count=3, wb_ready=1, next head is entry 2.
REQ-025 Push cached 0x2000 (A), cached 0x3000 (B), cached 0x3010 data D2 -> count=2, B wdata = D2; then uncached 0x3004 -> count=3, no merge.
REQ-026 With cached 0x4000 data D buffered, rd_addr=0x4018 -> rd_hit=1, rd_fwd_valid=1, rd_fwd_data=D; then push uncached 0x4004 -> rd_hit=1, rd_fwd_valid=0.
REQ-027 count=1, push and data_waddr_ok same cycle -> count stays 1, data_waddr shows new entry next cycle; wrap 10 entries through DEPTH=4 -> order preserved.
REQ-028 Assert resetn for one cycle with count=3 mid-handshake -> data_wreq=0, count=0, wb_ready=1 immediately, no further pops.
